// File: rtl/dte_pkg.sv
// dte_pkg: shared types for the diagnostic front-end request engine.
//   tReqType      - console request classes
//   tDiagFunction - DTE_MISC service codes carried on diag_req
package dte_pkg;

    typedef enum logic [2:0] {
        DTE_MISC      = 3'd0,
        DTE_WRITE     = 3'd1,
        DTE_DIAG_FUNC = 3'd2,
        DTE_READ      = 3'd3,
        DTE_RELEASE   = 3'd4
    } tReqType;

    typedef enum logic [6:0] {
        CLR_CROBAR = 7'o100,
        GET_APRID  = 7'o101,
        READ_MEM   = 7'o102,
        WRITE_MEM  = 7'o103,
        GET_DIAG1  = 7'o104
    } tDiagFunction;

endpackage

// File: rtl/dte_final.sv
// dte_final: timed DTE request engine.
//   Host side : req_valid/req_ready handshake plus req_time, req_type,
//               diag_req, req_data1, req_data2; one-cycle rsp_valid with
//               rsp_time and the 18,,18 reply rsp_lh/rsp_rh.
//   EBUS side : ebus_ds, ebus_diag_strobe, ebus_drive, ebus_drive_data out;
//               resolved ebus_data in.
//   Memory    : mem_addr, mem_we, mem_wdata out; combinational mem_rdata in.
//   Misc      : ucode version / hw_options / console status in; crobar out.
// Words use PDP-10 numbering (bit 0 = MSB), so PDP bits 0:17 are [35:18].
module dte_final
    import dte_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_time,
    input  logic [2:0]        req_type,
    input  logic [6:0]        diag_req,
    input  logic [35:0]       req_data1,
    input  logic [35:0]       req_data2,
    output logic              rsp_valid,
    output logic [63:0]       rsp_time,
    output logic [17:0]       rsp_lh,
    output logic [17:0]       rsp_rh,
    output logic [6:0]        ebus_ds,
    output logic              ebus_diag_strobe,
    output logic              ebus_drive,
    output logic [35:0]       ebus_drive_data,
    input  logic [35:0]       ebus_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [35:0]       mem_wdata,
    input  logic [35:0]       mem_rdata,
    input  logic [5:0]        ucode_major,
    input  logic [2:0]        ucode_minor,
    input  logic [8:0]        ucode_edit,
    input  logic [17:0]       hw_options,
    input  logic              con_run,
    input  logic              con_ebox_halted,
    output logic              crobar
);

    logic [63:0] ticks_q, ticks_d;
    logic        pending_q, pending_d;
    logic [63:0] time_q, time_d;
    logic [2:0]  type_q, type_d;
    logic [6:0]  diag_q, diag_d;
    logic [35:0] data1_q, data1_d;
    logic [35:0] data2_q, data2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_time_q, rsp_time_d;
    logic [17:0] rsp_lh_q, rsp_lh_d;
    logic [17:0] rsp_rh_q, rsp_rh_d;
    logic [6:0]  ebus_ds_q, ebus_ds_d;
    logic        strobe_q, strobe_d;
    logic        drive_q, drive_d;
    logic [35:0] drive_data_q, drive_data_d;
    logic        mem_we_q, mem_we_d;
    logic [35:0] mem_wdata_q, mem_wdata_d;
    logic        crobar_q, crobar_d;
    logic        execute;

    assign execute = pending_q && (ticks_q >= time_q);

    always_comb begin
        ticks_d      = ticks_q + 64'd1;
        pending_d    = pending_q;
        time_d       = time_q;
        type_d       = type_q;
        diag_d       = diag_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        rsp_valid_d  = 1'b0;
        rsp_time_d   = rsp_time_q;
        rsp_lh_d     = rsp_lh_q;
        rsp_rh_d     = rsp_rh_q;
        ebus_ds_d    = ebus_ds_q;
        strobe_d     = strobe_q;
        drive_d      = drive_q;
        drive_data_d = drive_data_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        crobar_d     = crobar_q;

        if (execute) begin
            pending_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_time_d  = ticks_q;
            rsp_lh_d    = 18'd0;
            rsp_rh_d    = 18'd0;
            case (type_q)
                DTE_WRITE: begin
                    rsp_lh_d     = ebus_data[35:18];
                    rsp_rh_d     = ebus_data[17:0];
                    ebus_ds_d    = diag_q;
                    strobe_d     = 1'b1;
                    drive_d      = 1'b1;
                    drive_data_d = data1_q;
                end
                DTE_DIAG_FUNC: begin
                    rsp_lh_d  = ebus_data[35:18];
                    rsp_rh_d  = ebus_data[17:0];
                    ebus_ds_d = diag_q;
                    strobe_d  = 1'b1;
                end
                DTE_READ: begin
                    rsp_lh_d = ebus_data[35:18];
                    rsp_rh_d = ebus_data[17:0];
                end
                DTE_RELEASE: begin
                    rsp_lh_d     = ebus_data[35:18];
                    rsp_rh_d     = ebus_data[17:0];
                    strobe_d     = 1'b0;
                    drive_d      = 1'b0;
                    drive_data_d = 36'd0;
                end
                DTE_MISC: begin
                    case (diag_q)
                        CLR_CROBAR: crobar_d = 1'b0;
                        GET_APRID: begin
                            rsp_lh_d = {ucode_major, ucode_minor, ucode_edit};
                            rsp_rh_d = hw_options;
                        end
                        READ_MEM: begin
                            rsp_lh_d = mem_rdata[35:18];
                            rsp_rh_d = mem_rdata[17:0];
                        end
                        WRITE_MEM: begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = data2_q;
                        end
                        GET_DIAG1: rsp_rh_d = {16'd0, con_run, con_ebox_halted};
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (req_valid && !pending_q) begin
            pending_d = 1'b1;
            time_d    = req_time;
            type_d    = req_type;
            diag_d    = diag_req;
            data1_d   = req_data1;
            data2_d   = req_data2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ticks_q      <= 64'd0;
            pending_q    <= 1'b0;
            time_q       <= 64'd0;
            type_q       <= 3'd0;
            diag_q       <= 7'd0;
            data1_q      <= 36'd0;
            data2_q      <= 36'd0;
            rsp_valid_q  <= 1'b0;
            rsp_time_q   <= 64'd0;
            rsp_lh_q     <= 18'd0;
            rsp_rh_q     <= 18'd0;
            ebus_ds_q    <= 7'd0;
            strobe_q     <= 1'b0;
            drive_q      <= 1'b0;
            drive_data_q <= 36'd0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 36'd0;
            crobar_q     <= 1'b1;
        end else begin
            ticks_q      <= ticks_d;
            pending_q    <= pending_d;
            time_q       <= time_d;
            type_q       <= type_d;
            diag_q       <= diag_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_time_q   <= rsp_time_d;
            rsp_lh_q     <= rsp_lh_d;
            rsp_rh_q     <= rsp_rh_d;
            ebus_ds_q    <= ebus_ds_d;
            strobe_q     <= strobe_d;
            drive_q      <= drive_d;
            drive_data_q <= drive_data_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            crobar_q     <= crobar_d;
        end
    end

    assign req_ready        = !pending_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_time         = rsp_time_q;
    assign rsp_lh           = rsp_lh_q;
    assign rsp_rh           = rsp_rh_q;
    assign ebus_ds          = ebus_ds_q;
    assign ebus_diag_strobe = strobe_q;
    assign ebus_drive       = drive_q;
    assign ebus_drive_data  = drive_data_q;
    // Address follows the latched request so mem_rdata is settled by execute.
    assign mem_addr         = data1_q[ADDR_W-1:0];
    assign mem_we           = mem_we_q;
    assign mem_wdata        = mem_wdata_q;
    assign crobar           = crobar_q;

endmodule

// File: tb/tb_dte_final.sv
// tb_dte_final: directed bench for dte_final with a reply scoreboard.
module tb_dte_final;
    import dte_pkg::*;

    localparam logic [35:0] EBUS_BG = 36'o111222333444;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_time;
    logic [2:0]  req_type;
    logic [6:0]  diag_req;
    logic [35:0] req_data1, req_data2;
    logic        rsp_valid;
    logic [63:0] rsp_time;
    logic [17:0] rsp_lh, rsp_rh;
    logic [6:0]  ebus_ds;
    logic        ebus_diag_strobe, ebus_drive;
    logic [35:0] ebus_drive_data, ebus_data;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_wdata, mem_rdata;
    logic [5:0]  ucode_major;
    logic [2:0]  ucode_minor;
    logic [8:0]  ucode_edit;
    logic [17:0] hw_options;
    logic        con_run, con_ebox_halted;
    logic        crobar;

    dte_final #(.ADDR_W(18)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_time(req_time),
        .req_type(req_type), .diag_req(diag_req),
        .req_data1(req_data1), .req_data2(req_data2),
        .rsp_valid(rsp_valid), .rsp_time(rsp_time), .rsp_lh(rsp_lh), .rsp_rh(rsp_rh),
        .ebus_ds(ebus_ds), .ebus_diag_strobe(ebus_diag_strobe),
        .ebus_drive(ebus_drive), .ebus_drive_data(ebus_drive_data), .ebus_data(ebus_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ucode_major(ucode_major), .ucode_minor(ucode_minor), .ucode_edit(ucode_edit),
        .hw_options(hw_options), .con_run(con_run), .con_ebox_halted(con_ebox_halted),
        .crobar(crobar)
    );

    always #30 clk = ~clk;

    // EBUS resolution and a small memory that echoes writes.
    assign ebus_data = ebus_drive ? ebus_drive_data : EBUS_BG;
    logic [35:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

    // Reference tick count.
    logic [63:0] cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 64'd0;
        else        cyc <= cyc + 64'd1;

    typedef struct {
        logic [17:0] lh;
        logic [17:0] rh;
        logic [63:0] t;
        bit          chk_t;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int rsp_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        snap_mem_we;
    logic [17:0] snap_mem_addr;
    logic [35:0] snap_mem_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    // Reply monitor: pops the scoreboard on each rsp_valid.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            exp_t e;
            chk("rsp_pulse_single", {63'd0, prev_valid}, 64'd0);
            snap_mem_we    = mem_we;
            snap_mem_addr  = mem_addr;
            snap_mem_wdata = mem_wdata;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_lh", {46'd0, rsp_lh}, {46'd0, e.lh});
                chk("rsp_rh", {46'd0, rsp_rh}, {46'd0, e.rh});
                if (e.chk_t) chk("rsp_time", rsp_time, e.t);
            end
            rsp_cnt++;
        end
        prev_valid = rst_n && rsp_valid;
    end

    task automatic offer(input logic [2:0] ty, input logic [6:0] dg,
                         input logic [35:0] d1, input logic [35:0] d2,
                         input bit rel, input logic [63:0] t,
                         input logic [17:0] lh, input logic [17:0] rh, input bit chk_t);
        exp_t e;
        bit   ok = 0;
        @(negedge clk);
        req_type  = ty;
        diag_req  = dg;
        req_data1 = d1;
        req_data2 = d2;
        req_time  = rel ? cyc + t : t;
        req_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        e.lh = lh; e.rh = rh; e.t = req_time; e.chk_t = chk_t;
        if (ok) sb.push_back(e);
        else    chk("accept_timeout", 64'd1, 64'd0);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (rsp_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("rsp_timeout", 64'(rsp_cnt), 64'(target));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_time = '0; req_type = '0; diag_req = '0;
        req_data1 = '0; req_data2 = '0;
        ucode_major = 6'o12; ucode_minor = 3'o3; ucode_edit = 9'o442;
        hw_options = 18'o400000;
        con_run = 1'b1; con_ebox_halted = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 36'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_crobar", {63'd0, crobar}, 64'd1);
        chk("reset_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_drive", {63'd0, ebus_drive}, 64'd0);
        chk("reset_mem_we", {63'd0, mem_we}, 64'd0);

        offer(DTE_MISC, CLR_CROBAR, 36'd0, 36'd0, 0, 64'd0, 18'd0, 18'd0, 0);
        wait_rsp(1);
        chk("crobar_cleared", {63'd0, crobar}, 64'd0);

        offer(DTE_MISC, GET_APRID, 36'd0, 36'd0, 0, 64'd0, 18'o123442, 18'o400000, 0);
        wait_rsp(2);

        offer(DTE_MISC, WRITE_MEM, 36'o1000, 36'o123456654321, 0, 64'd0, 18'd0, 18'd0, 0);
        wait_rsp(3);
        chk("wmem_we", {63'd0, snap_mem_we}, 64'd1);
        chk("wmem_addr", {46'd0, snap_mem_addr}, 64'o1000);
        chk("wmem_wdata", {28'd0, snap_mem_wdata}, 64'o123456654321);
        @(negedge clk);
        chk("wmem_we_one_cycle", {63'd0, mem_we}, 64'd0);

        offer(DTE_MISC, READ_MEM, 36'o1000, 36'd0, 0, 64'd0, 18'o123456, 18'o654321, 0);
        wait_rsp(4);

        offer(DTE_WRITE, 7'o71, 36'o777, 36'd0, 0, 64'd0, EBUS_BG[35:18], EBUS_BG[17:0], 0);
        wait_rsp(5);
        chk("wr_drive", {63'd0, ebus_drive}, 64'd1);
        chk("wr_drive_data", {28'd0, ebus_drive_data}, 64'o777);
        chk("wr_strobe", {63'd0, ebus_diag_strobe}, 64'd1);
        chk("wr_ds", {57'd0, ebus_ds}, 64'o71);

        offer(DTE_READ, 7'o0, 36'd0, 36'd0, 0, 64'd0, 18'd0, 18'o777, 0);
        wait_rsp(6);

        offer(DTE_RELEASE, 7'o0, 36'd0, 36'd0, 0, 64'd0, 18'd0, 18'o777, 0);
        wait_rsp(7);
        chk("rel_drive", {63'd0, ebus_drive}, 64'd0);
        chk("rel_strobe", {63'd0, ebus_diag_strobe}, 64'd0);
        chk("rel_data", {28'd0, ebus_drive_data}, 64'd0);
        chk("rel_ds_hold", {57'd0, ebus_ds}, 64'o71);

        offer(3'd7, CLR_CROBAR, 36'o5, 36'o5, 0, 64'd0, 18'd0, 18'd0, 0);
        wait_rsp(8);
        chk("undef_no_drive", {63'd0, ebus_drive}, 64'd0);

        // Timed request with a second one stalled behind it.
        offer(DTE_MISC, GET_APRID, 36'd0, 36'd0, 1, 64'd100, 18'o123442, 18'o400000, 1);
        @(negedge clk);
        chk("timed_busy", {63'd0, req_ready}, 64'd0);
        offer(DTE_MISC, GET_DIAG1, 36'd0, 36'd0, 0, 64'd0, 18'd0, 18'd2, 0);
        wait_rsp(10);

        // Reset while a request is pending.
        offer(DTE_MISC, GET_APRID, 36'd0, 36'd0, 1, 64'd50, 18'o123442, 18'o400000, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_crobar", {63'd0, crobar}, 64'd1);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_lh", {46'd0, rsp_lh}, 64'd0);
        chk("rst_rsp_time", rsp_time, 64'd0);
        chk("rst_ds", {57'd0, ebus_ds}, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("rst_no_reply", 64'(rsp_cnt), 64'd10);
        chk("rst_ready_after", {63'd0, req_ready}, 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
